// File: rtl/rv32_rf_pkg.sv
// Shared constants, types and helpers for the multi-port integer register file.
// The write-resolution helper is the single source of "highest port wins".
package rv32_rf_pkg;

    localparam int unsigned ZERO_ADDR = 0;
    localparam int unsigned MAX_WR    = 8;
    localparam int unsigned WP_W      = 3;

    typedef struct packed {
        logic            hit;
        logic [WP_W-1:0] idx;
    } wr_sel_t;

    function automatic int unsigned rf_addr_w(input int unsigned nregs);
        return (nregs > 2) ? $clog2(nregs) : 1;
    endfunction

    // Later ports overwrite earlier ones, so the highest matching index survives.
    function automatic wr_sel_t resolve_wr(input logic [MAX_WR-1:0] match);
        wr_sel_t sel;
        sel.hit = 1'b0;
        sel.idx = '0;
        for (int w = 0; w < int'(MAX_WR); w++) begin
            if (match[w]) begin
                sel.hit = 1'b1;
                sel.idx = WP_W'(w);
            end
        end
        return sel;
    endfunction

endpackage

// File: rtl/rv32_regfile_mp_if.sv
// Decode/writeback-side signal bundle of the multi-port register file.
interface rv32_regfile_mp_if
    import rv32_rf_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NREGS  = 32,
    parameter int unsigned NUM_RD = 2,
    parameter int unsigned NUM_WR = 1
);
    localparam int unsigned AW = rf_addr_w(NREGS);

    // No handshake: every input is sampled at every rising edge; read results appear
    // one edge after rd_en_in[p] and hold while rd_en_in[p] stays low.
    logic [NUM_RD-1:0]      rd_en_in;
    logic [NUM_RD*AW-1:0]   rs_addr_in;
    logic [NUM_RD*XLEN-1:0] rs_out;
    logic [NUM_RD-1:0]      rs_busy_out;
    logic [NUM_WR-1:0]      wr_en_in;
    logic [NUM_WR*AW-1:0]   wr_addr_in;
    logic [NUM_WR*XLEN-1:0] wr_data_in;
    logic                   rsv_en_in;
    logic [AW-1:0]          rsv_addr_in;
    logic                   flush_in;

    modport master (
        output rd_en_in, rs_addr_in, wr_en_in, wr_addr_in, wr_data_in,
               rsv_en_in, rsv_addr_in, flush_in,
        input  rs_out, rs_busy_out
    );

    modport slave (
        input  rd_en_in, rs_addr_in, wr_en_in, wr_addr_in, wr_data_in,
               rsv_en_in, rsv_addr_in, flush_in,
        output rs_out, rs_busy_out
    );

endinterface

// File: rtl/rv32_rf_read_port.sv
// One registered read port: array select, x0/out-of-range zeroing, optional
// same-cycle write bypass and next-state busy lookup.
module rv32_rf_read_port
    import rv32_rf_pkg::*;
#(
    parameter  int unsigned XLEN   = 32,
    parameter  int unsigned NREGS  = 32,
    parameter  int unsigned NUM_WR = 1,
    parameter  int unsigned BYPASS = 1,
    localparam int unsigned AW     = rf_addr_w(NREGS)
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   rd_en_i,
    input  logic [AW-1:0]          rs_addr_i,
    input  logic [XLEN-1:0]        regs_i [NREGS],
    input  logic [NREGS-1:0]       busy_d_i,
    input  logic [NUM_WR-1:0]      wr_en_i,
    input  logic [NUM_WR*AW-1:0]   wr_addr_i,
    input  logic [NUM_WR*XLEN-1:0] wr_data_i,
    output logic [XLEN-1:0]        rs_o,
    output logic                   rs_busy_o
);

    logic              addr_ok;
    logic [MAX_WR-1:0] wr_match;
    wr_sel_t           wr_sel;
    logic [XLEN-1:0]   byp_data;
    logic [XLEN-1:0]   rs_d;
    logic              rs_busy_d;
    logic [XLEN-1:0]   rs_q;
    logic              rs_busy_q;

    always_comb begin
        addr_ok = (int'(rs_addr_i) < int'(NREGS)) && (int'(rs_addr_i) != int'(ZERO_ADDR));

        wr_match = '0;
        for (int w = 0; w < int'(NUM_WR); w++) begin
            wr_match[w] = wr_en_i[w] && (wr_addr_i[w*AW +: AW] == rs_addr_i);
        end
        wr_sel = resolve_wr(wr_match);

        byp_data = '0;
        for (int w = 0; w < int'(NUM_WR); w++) begin
            if (wr_sel.idx == WP_W'(w)) byp_data = wr_data_i[w*XLEN +: XLEN];
        end

        rs_d = addr_ok ? regs_i[rs_addr_i] : '0;
        if ((BYPASS != 0) && addr_ok && wr_sel.hit) rs_d = byp_data;

        // Next-state busy so a same-cycle reserve or write-clear is visible at once.
        rs_busy_d = addr_ok && busy_d_i[rs_addr_i];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rs_q      <= '0;
            rs_busy_q <= 1'b0;
        end else if (rd_en_i) begin
            rs_q      <= rs_d;
            rs_busy_q <= rs_busy_d;
        end
    end

    assign rs_o      = rs_q;
    assign rs_busy_o = rs_busy_q;

endmodule

// File: rtl/rv32_regfile_mp.sv
// Multi-port RV32 integer register file with a per-register busy scoreboard.
// Holds the register array, write decode and busy vector; read ports are sub-modules.
module rv32_regfile_mp
    import rv32_rf_pkg::*;
#(
    parameter  int unsigned XLEN   = 32,
    parameter  int unsigned NREGS  = 32,
    parameter  int unsigned NUM_RD = 2,
    parameter  int unsigned NUM_WR = 1,
    parameter  int unsigned BYPASS = 1,
    localparam int unsigned AW     = rf_addr_w(NREGS)
) (
    input  logic              riscv32_mp_clk_in,
    input  logic              riscv32_mp_rst_in,
    rv32_regfile_mp_if.slave  bus
);

    logic [XLEN-1:0]   regs_q [NREGS];
    logic [XLEN-1:0]   regs_d [NREGS];
    logic [NREGS-1:0]  busy_q;
    logic [NREGS-1:0]  busy_d;
    logic [NREGS-1:0]  wr_hit;
    logic [MAX_WR-1:0] match;
    wr_sel_t           sel;

    always_comb begin
        match  = '0;
        sel    = '0;
        wr_hit = '0;
        for (int r = 0; r < int'(NREGS); r++) begin
            match = '0;
            for (int w = 0; w < int'(NUM_WR); w++) begin
                match[w] = bus.wr_en_in[w] && (bus.wr_addr_in[w*AW +: AW] == AW'(r));
            end
            sel       = resolve_wr(match);
            wr_hit[r] = sel.hit;
            regs_d[r] = regs_q[r];
            for (int w = 0; w < int'(NUM_WR); w++) begin
                if (sel.hit && (sel.idx == WP_W'(w))) regs_d[r] = bus.wr_data_in[w*XLEN +: XLEN];
            end
        end
        regs_d[ZERO_ADDR] = '0;

        // Priority: flush over reserve over write-clear over hold.
        for (int r = 0; r < int'(NREGS); r++) begin
            busy_d[r] = busy_q[r];
            if (wr_hit[r]) busy_d[r] = 1'b0;
            if (bus.rsv_en_in && (bus.rsv_addr_in == AW'(r))) busy_d[r] = 1'b1;
        end
        if (bus.flush_in) busy_d = '0;
        busy_d[ZERO_ADDR] = 1'b0;
    end

    always_ff @(posedge riscv32_mp_clk_in or negedge riscv32_mp_rst_in) begin
        if (!riscv32_mp_rst_in) begin
            regs_q <= '{default: '0};
            busy_q <= '0;
        end else begin
            regs_q <= regs_d;
            busy_q <= busy_d;
        end
    end

    logic [XLEN-1:0] rs_data [NUM_RD];
    logic            rs_busy [NUM_RD];

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        rv32_rf_read_port #(
            .XLEN   (XLEN),
            .NREGS  (NREGS),
            .NUM_WR (NUM_WR),
            .BYPASS (BYPASS)
        ) u_port (
            .clk_i     (riscv32_mp_clk_in),
            .rst_ni    (riscv32_mp_rst_in),
            .rd_en_i   (bus.rd_en_in[p]),
            .rs_addr_i (bus.rs_addr_in[p*AW +: AW]),
            .regs_i    (regs_q),
            .busy_d_i  (busy_d),
            .wr_en_i   (bus.wr_en_in),
            .wr_addr_i (bus.wr_addr_in),
            .wr_data_i (bus.wr_data_in),
            .rs_o      (rs_data[p]),
            .rs_busy_o (rs_busy[p])
        );
    end

    always_comb begin
        bus.rs_out      = '0;
        bus.rs_busy_out = '0;
        for (int p = 0; p < int'(NUM_RD); p++) begin
            bus.rs_out[p*XLEN +: XLEN] = rs_data[p];
            bus.rs_busy_out[p]         = rs_busy[p];
        end
    end

endmodule

// File: tb/tb_rv32_regfile_mp.sv
// Bench for rv32_regfile_mp: bypassing dual-write instance plus a non-bypassing
// single-write instance, checked through vector tables, a reference model and hand sequences.
module tb_rv32_regfile_mp;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rv32_regfile_mp_if #(.XLEN(32), .NREGS(32), .NUM_RD(2), .NUM_WR(2)) bus_a ();
    rv32_regfile_mp_if #(.XLEN(32), .NREGS(32), .NUM_RD(2), .NUM_WR(1)) bus_b ();

    rv32_regfile_mp #(.XLEN(32), .NREGS(32), .NUM_RD(2), .NUM_WR(2), .BYPASS(1)) dut_a (
        .riscv32_mp_clk_in (clk),
        .riscv32_mp_rst_in (rst_n),
        .bus               (bus_a)
    );

    rv32_regfile_mp #(.XLEN(32), .NREGS(32), .NUM_RD(2), .NUM_WR(1), .BYPASS(0)) dut_b (
        .riscv32_mp_clk_in (clk),
        .riscv32_mp_rst_in (rst_n),
        .bus               (bus_b)
    );

    int n_checks = 0;
    int n_errors = 0;
    logic [32:0] exp_q [$];

    typedef struct {
        logic [1:0]  rd;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        rsv;
        logic [4:0]  rsa;
        logic        fl;
        logic [31:0] e0;
        logic        b0;
        logic [31:0] e1;
        logic        b1;
    } vec_t;

    vec_t vecs [16];

    logic [31:0] m_regs [32];
    logic [31:0] m_busy;
    logic [32:0] m_last [2];

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got busy=%b data=%h, expected busy=%b data=%h",
                     name, act[32], act[31:0], exp[32], exp[31:0]);
        end
    endtask

    function automatic logic [32:0] port_a(input int p);
        return {bus_a.rs_busy_out[p], bus_a.rs_out[p*32 +: 32]};
    endfunction

    function automatic logic [32:0] port_b(input int p);
        return {bus_b.rs_busy_out[p], bus_b.rs_out[p*32 +: 32]};
    endfunction

    task automatic drive_a(input logic [1:0] rd, input logic [4:0] ra0, input logic [4:0] ra1,
                           input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
                           input logic [4:0] wa1, input logic [31:0] wd1,
                           input logic rsv, input logic [4:0] rsa, input logic fl);
        bus_a.rd_en_in    = rd;
        bus_a.rs_addr_in  = {ra1, ra0};
        bus_a.wr_en_in    = we;
        bus_a.wr_addr_in  = {wa1, wa0};
        bus_a.wr_data_in  = {wd1, wd0};
        bus_a.rsv_en_in   = rsv;
        bus_a.rsv_addr_in = rsa;
        bus_a.flush_in    = fl;
    endtask

    task automatic drive_b(input logic [1:0] rd, input logic [4:0] ra0, input logic [4:0] ra1,
                           input logic we, input logic [4:0] wa, input logic [31:0] wd,
                           input logic rsv, input logic [4:0] rsa);
        bus_b.rd_en_in    = rd;
        bus_b.rs_addr_in  = {ra1, ra0};
        bus_b.wr_en_in    = we;
        bus_b.wr_addr_in  = wa;
        bus_b.wr_data_in  = wd;
        bus_b.rsv_en_in   = rsv;
        bus_b.rsv_addr_in = rsa;
        bus_b.flush_in    = 1'b0;
    endtask

    // Reference behaviour of one clock edge for the bypassing instance.
    task automatic model_push(input logic [1:0] rd, input logic [4:0] ra0, input logic [4:0] ra1,
                              input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
                              input logic [4:0] wa1, input logic [31:0] wd1,
                              input logic rsv, input logic [4:0] rsa, input logic fl);
        logic [31:0] nb;
        logic [4:0]  wa [2];
        logic [31:0] wd [2];
        logic [4:0]  ra [2];
        logic [31:0] d;
        wa[0] = wa0; wa[1] = wa1; wd[0] = wd0; wd[1] = wd1; ra[0] = ra0; ra[1] = ra1;
        nb = m_busy;
        for (int w = 0; w < 2; w++) if (we[w] && wa[w] != 5'd0) nb[wa[w]] = 1'b0;
        if (rsv && rsa != 5'd0) nb[rsa] = 1'b1;
        if (fl) nb = '0;
        for (int p = 0; p < 2; p++) begin
            if (rd[p]) begin
                d = (ra[p] == 5'd0) ? 32'd0 : m_regs[ra[p]];
                for (int w = 0; w < 2; w++)
                    if (we[w] && wa[w] == ra[p] && ra[p] != 5'd0) d = wd[w];
                m_last[p] = {(ra[p] != 5'd0) && nb[ra[p]], d};
            end
            exp_q.push_back(m_last[p]);
        end
        for (int w = 0; w < 2; w++) if (we[w] && wa[w] != 5'd0) m_regs[wa[w]] = wd[w];
        m_busy = nb;
    endtask

    task automatic tick_check(input string tag);
        logic [32:0] exp;
        @(posedge clk);
        #1;
        for (int p = 0; p < 2; p++) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL %s port%0d: no expected entry, got %h", tag, p, port_a(p));
            end else begin
                n_checks--;
                exp = exp_q.pop_front();
                check($sformatf("%s port%0d", tag, p), port_a(p), exp);
            end
        end
    endtask

    initial begin
        vecs[0]  = '{2'b00, 5'd0,  5'd0,  2'b01, 5'd5,  32'hDEADBEEF, 5'd0,  32'h0,    1'b0, 5'd0, 1'b0, 32'h0,        1'b0, 32'h0,    1'b0};
        vecs[1]  = '{2'b01, 5'd5,  5'd0,  2'b00, 5'd0,  32'h0,        5'd0,  32'h0,    1'b0, 5'd0, 1'b0, 32'hDEADBEEF, 1'b0, 32'h0,    1'b0};
        vecs[2]  = '{2'b10, 5'd0,  5'd7,  2'b01, 5'd7,  32'h1234,     5'd0,  32'h0,    1'b0, 5'd0, 1'b0, 32'hDEADBEEF, 1'b0, 32'h1234, 1'b0};
        vecs[3]  = '{2'b01, 5'd9,  5'd0,  2'b11, 5'd9,  32'hAAAA,     5'd9,  32'h5555, 1'b0, 5'd0, 1'b0, 32'h5555,     1'b0, 32'h1234, 1'b0};
        vecs[4]  = '{2'b10, 5'd0,  5'd9,  2'b00, 5'd0,  32'h0,        5'd0,  32'h0,    1'b0, 5'd0, 1'b0, 32'h5555,     1'b0, 32'h5555, 1'b0};
        vecs[5]  = '{2'b11, 5'd0,  5'd0,  2'b01, 5'd0,  32'hFFFFFFFF, 5'd0,  32'h0,    1'b1, 5'd0, 1'b0, 32'h0,        1'b0, 32'h0,    1'b0};
        vecs[6]  = '{2'b01, 5'd3,  5'd0,  2'b00, 5'd0,  32'h0,        5'd0,  32'h0,    1'b1, 5'd3, 1'b0, 32'h0,        1'b1, 32'h0,    1'b0};
        vecs[7]  = '{2'b11, 5'd3,  5'd3,  2'b01, 5'd3,  32'h33,       5'd0,  32'h0,    1'b1, 5'd3, 1'b0, 32'h33,       1'b1, 32'h33,   1'b1};
        vecs[8]  = '{2'b10, 5'd0,  5'd3,  2'b01, 5'd3,  32'h44,       5'd0,  32'h0,    1'b0, 5'd0, 1'b0, 32'h33,       1'b1, 32'h44,   1'b0};
        vecs[9]  = '{2'b01, 5'd4,  5'd0,  2'b00, 5'd0,  32'h0,        5'd0,  32'h0,    1'b1, 5'd4, 1'b0, 32'h0,        1'b1, 32'h44,   1'b0};
        vecs[10] = '{2'b01, 5'd4,  5'd0,  2'b00, 5'd0,  32'h0,        5'd0,  32'h0,    1'b1, 5'd4, 1'b1, 32'h0,        1'b0, 32'h44,   1'b0};
        vecs[11] = '{2'b10, 5'd0,  5'd4,  2'b00, 5'd0,  32'h0,        5'd0,  32'h0,    1'b0, 5'd0, 1'b0, 32'h0,        1'b0, 32'h0,    1'b0};
        vecs[12] = '{2'b00, 5'd0,  5'd0,  2'b11, 5'd10, 32'h1,        5'd11, 32'h2,    1'b0, 5'd0, 1'b0, 32'h0,        1'b0, 32'h0,    1'b0};
        vecs[13] = '{2'b11, 5'd10, 5'd11, 2'b00, 5'd0,  32'h0,        5'd0,  32'h0,    1'b0, 5'd0, 1'b0, 32'h1,        1'b0, 32'h2,    1'b0};
        vecs[14] = '{2'b00, 5'd5,  5'd3,  2'b00, 5'd0,  32'h0,        5'd0,  32'h0,    1'b0, 5'd0, 1'b0, 32'h1,        1'b0, 32'h2,    1'b0};
        vecs[15] = '{2'b11, 5'd7,  5'd7,  2'b00, 5'd0,  32'h0,        5'd0,  32'h0,    1'b0, 5'd0, 1'b0, 32'h1234,     1'b0, 32'h1234, 1'b0};

        drive_a(2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
        drive_b(2'b00, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        for (int p = 0; p < 2; p++) begin
            check($sformatf("reset_a port%0d", p), port_a(p), 33'h0);
            check($sformatf("reset_b port%0d", p), port_b(p), 33'h0);
        end
        #2 rst_n = 1'b1;

        // Directed vectors.
        for (int i = 0; i < 16; i++) begin
            drive_a(vecs[i].rd, vecs[i].ra0, vecs[i].ra1, vecs[i].we, vecs[i].wa0, vecs[i].wd0,
                    vecs[i].wa1, vecs[i].wd1, vecs[i].rsv, vecs[i].rsa, vecs[i].fl);
            exp_q.push_back({vecs[i].b0, vecs[i].e0});
            exp_q.push_back({vecs[i].b1, vecs[i].e1});
            tick_check($sformatf("vec%0d", i));
        end

        // Asynchronous reset asserted mid-cycle while traffic keeps flowing.
        drive_a(2'b11, 5'd7, 5'd3, 2'b11, 5'd12, 32'hCAFE, 5'd13, 32'hF00D, 1'b1, 5'd14, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        for (int p = 0; p < 2; p++) check($sformatf("async_rst port%0d", p), port_a(p), 33'h0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        drive_a(2'b11, 5'd5, 5'd7, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
        exp_q.push_back(33'h0); exp_q.push_back(33'h0);
        tick_check("post_rst x5/x7");
        drive_a(2'b11, 5'd9, 5'd14, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);
        exp_q.push_back(33'h0); exp_q.push_back(33'h0);
        tick_check("post_rst x9/x14");

        // Random traffic against the reference model.
        for (int r = 0; r < 32; r++) m_regs[r] = 32'h0;
        m_busy = '0;
        m_last[0] = 33'h0;
        m_last[1] = 33'h0;
        for (int i = 0; i < 300; i++) begin
            logic [1:0]  rd, we;
            logic [4:0]  ra0, ra1, wa0, wa1, rsa;
            logic [31:0] wd0, wd1;
            logic        rsv, fl;
            rd  = 2'($urandom_range(0, 3));
            ra0 = 5'($urandom_range(0, 31));
            ra1 = 5'($urandom_range(0, 31));
            we  = 2'($urandom_range(0, 3));
            wa0 = 5'($urandom_range(0, 31));
            wa1 = ($urandom_range(0, 3) == 0) ? wa0 : 5'($urandom_range(0, 31));
            wd0 = $urandom;
            wd1 = $urandom;
            rsv = ($urandom_range(0, 2) == 0);
            rsa = ($urandom_range(0, 3) == 0) ? wa0 : 5'($urandom_range(0, 31));
            fl  = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 2) == 0) ra0 = wa1;
            drive_a(rd, ra0, ra1, we, wa0, wd0, wa1, wd1, rsv, rsa, fl);
            model_push(rd, ra0, ra1, we, wa0, wd0, wa1, wd1, rsv, rsa, fl);
            tick_check($sformatf("rand%0d", i));
        end
        drive_a(2'b00, 5'd0, 5'd0, 2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0);

        // Non-bypassing instance: same-cycle reads return the pre-write value.
        drive_b(2'b01, 5'd7, 5'd0, 1'b1, 5'd7, 32'h1234, 1'b0, 5'd0);
        @(posedge clk); #1;
        check("b_samecycle_x7", port_b(0), {1'b0, 32'h0});
        drive_b(2'b11, 5'd7, 5'd7, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        @(posedge clk); #1;
        check("b_read_x7 port0", port_b(0), {1'b0, 32'h1234});
        check("b_read_x7 port1", port_b(1), {1'b0, 32'h1234});
        drive_b(2'b10, 5'd0, 5'd2, 1'b1, 5'd2, 32'h77, 1'b1, 5'd2);
        @(posedge clk); #1;
        check("b_rsv_and_wr_x2", port_b(1), {1'b1, 32'h0});
        drive_b(2'b10, 5'd0, 5'd2, 1'b1, 5'd2, 32'hBEEF, 1'b0, 5'd0);
        @(posedge clk); #1;
        check("b_wr_clear_x2", port_b(1), {1'b0, 32'h77});
        drive_b(2'b10, 5'd0, 5'd2, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        @(posedge clk); #1;
        check("b_read_x2", port_b(1), {1'b0, 32'hBEEF});
        check("b_port0_hold", port_b(0), {1'b0, 32'h1234});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
